// File: rtl/sm3_msg_packer.sv
// Byte-stream front end for the SM3 core: packs bytes big-endian into 32-bit words
// with a byte mask and last flag, buffers them in a 2-entry FIFO and tracks message bit length.
module sm3_msg_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  byte_i,
    input  logic        byte_vld_i,
    input  logic        byte_lst_i,
    output logic        byte_rdy_o,
    input  logic        abort_i,
    output logic [31:0] msg_inpt_d_o,
    output logic [3:0]  msg_inpt_vld_byte_o,
    output logic        msg_inpt_vld_o,
    output logic        msg_inpt_lst_o,
    input  logic        msg_inpt_rdy_i,
    output logic [63:0] msg_len_bits_o,
    output logic        busy_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] part_q, part_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [63:0] len_q, len_d;

    // FIFO entry layout: {data[31:0], mask[3:0], lst}
    logic [36:0] fifo_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] push_data;
    logic [3:0]  push_mask;
    logic [36:0] head;

    assign byte_rdy_o = (cnt_q != 2'd2);
    assign accept     = byte_vld_i & byte_rdy_o;
    assign push       = accept & ((bidx_q == 2'd3) | byte_lst_i);
    assign pop        = (cnt_q != 2'd0) & msg_inpt_rdy_i;

    // Lanes below bidx come from the partial word, lane bidx is the new byte, the rest are zero.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        if (gi < 3) begin : g_part
            assign push_data[31-8*gi -: 8] = (bidx_q == 2'(gi)) ? byte_i :
                                             (bidx_q >  2'(gi)) ? part_q[23-8*gi -: 8] : 8'h00;
        end else begin : g_last
            assign push_data[31-8*gi -: 8] = (bidx_q == 2'(gi)) ? byte_i : 8'h00;
        end
        assign push_mask[3-gi] = (bidx_q >= 2'(gi));
    end

    always_comb begin
        state_d = state_q;
        bidx_d  = bidx_q;
        len_d   = len_q;
        part_d  = part_q;
        if (abort_i) begin
            state_d = ST_IDLE;
            bidx_d  = 2'd0;
            len_d   = 64'd0;
            part_d  = 24'd0;
        end else if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    len_d = 64'd8;
                    if (byte_lst_i) begin
                        state_d = ST_IDLE;
                        bidx_d  = 2'd0;
                        part_d  = 24'd0;
                    end else begin
                        state_d = ST_ACTIVE;
                        bidx_d  = 2'd1;
                        part_d  = {byte_i, 16'h0000};
                    end
                end
                ST_ACTIVE: begin
                    len_d = len_q + 64'd8;
                    if (byte_lst_i) begin
                        state_d = ST_IDLE;
                        bidx_d  = 2'd0;
                    end else begin
                        bidx_d = bidx_q + 2'd1;
                    end
                    if (push) begin
                        part_d = 24'd0;
                    end else begin
                        case (bidx_q)
                            2'd0:    part_d[23:16] = byte_i;
                            2'd1:    part_d[15:8]  = byte_i;
                            default: part_d[7:0]   = byte_i;
                        endcase
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (abort_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            bidx_q   <= 2'd0;
            len_q    <= 64'd0;
            part_q   <= 24'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            bidx_q   <= bidx_d;
            len_q    <= len_d;
            part_q   <= part_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                fifo_q[gi] <= 37'd0;
            end else if (push && !abort_i && (wr_ptr_q == 1'(gi))) begin
                fifo_q[gi] <= {push_data, push_mask, byte_lst_i};
            end
        end
    end

    // Outputs are forced to zero while the FIFO is empty so stale entries never leak out.
    assign head                = fifo_q[rd_ptr_q];
    assign msg_inpt_vld_o      = (cnt_q != 2'd0);
    assign msg_inpt_d_o        = msg_inpt_vld_o ? head[36:5] : 32'd0;
    assign msg_inpt_vld_byte_o = msg_inpt_vld_o ? head[4:1]  : 4'd0;
    assign msg_inpt_lst_o      = msg_inpt_vld_o & head[0];
    assign msg_len_bits_o      = len_q;
    assign busy_o              = (state_q == ST_ACTIVE) | (cnt_q != 2'd0);

endmodule

// File: tb/tb_sm3_msg_packer.sv
// Scoreboard bench for sm3_msg_packer: expected words are queued by the stimulus,
// a negedge monitor pops and compares each word the DUT hands over.
module tb_sm3_msg_packer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  byte_i;
    logic        byte_vld_i;
    logic        byte_lst_i;
    logic        byte_rdy_o;
    logic        abort_i;
    logic [31:0] msg_inpt_d_o;
    logic [3:0]  msg_inpt_vld_byte_o;
    logic        msg_inpt_vld_o;
    logic        msg_inpt_lst_o;
    logic        msg_inpt_rdy_i;
    logic [63:0] msg_len_bits_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    sm3_msg_packer dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .byte_i              (byte_i),
        .byte_vld_i          (byte_vld_i),
        .byte_lst_i          (byte_lst_i),
        .byte_rdy_o          (byte_rdy_o),
        .abort_i             (abort_i),
        .msg_inpt_d_o        (msg_inpt_d_o),
        .msg_inpt_vld_byte_o (msg_inpt_vld_byte_o),
        .msg_inpt_vld_o      (msg_inpt_vld_o),
        .msg_inpt_lst_o      (msg_inpt_lst_o),
        .msg_inpt_rdy_i      (msg_inpt_rdy_i),
        .msg_len_bits_o      (msg_len_bits_o),
        .busy_o              (busy_o)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  m;
        logic        l;
    } word_t;

    word_t sb_q[$];
    int    n_cmp = 0;
    int    n_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] m, input logic l);
        word_t w;
        w.d = d;
        w.m = m;
        w.l = l;
        sb_q.push_back(w);
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte was accepted.
    task automatic send(input logic [7:0] b, input logic l);
        byte_i     = b;
        byte_vld_i = 1'b1;
        byte_lst_i = l;
        for (int i = 0; i < 100; i++) begin
            if (byte_rdy_o) begin
                @(posedge clk_i);
                #1;
                byte_vld_i = 1'b0;
                byte_lst_i = 1'b0;
                return;
            end
            @(posedge clk_i);
            #1;
        end
        n_cmp++;
        n_mis++;
        $display("FAIL send_timeout: byte %0h never accepted, required accept within 100 cycles", b);
        byte_vld_i = 1'b0;
        byte_lst_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50; i++) begin
            if (sb_q.size() == 0 && !msg_inpt_vld_o) break;
            @(posedge clk_i);
            #1;
        end
        chk(name, 64'(sb_q.size()), 64'd0);
    endtask

    always @(negedge clk_i) begin
        word_t got;
        word_t exp;
        if (rst_ni && msg_inpt_vld_o && msg_inpt_rdy_i) begin
            got.d = msg_inpt_d_o;
            got.m = msg_inpt_vld_byte_o;
            got.l = msg_inpt_lst_o;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_mis++;
                $display("FAIL word_unexpected: got d=%08h m=%04b l=%0b, required no word", got.d, got.m, got.l);
            end else begin
                exp = sb_q.pop_front();
                if (got !== exp) begin
                    n_mis++;
                    $display("FAIL word: got d=%08h m=%04b l=%0b, required d=%08h m=%04b l=%0b",
                             got.d, got.m, got.l, exp.d, exp.m, exp.l);
                end else begin
                    $display("ok   word: d=%08h m=%04b l=%0b", got.d, got.m, got.l);
                end
            end
        end
    end

    initial begin
        rst_ni         = 1'b0;
        byte_i         = 8'h00;
        byte_vld_i     = 1'b0;
        byte_lst_i     = 1'b0;
        abort_i        = 1'b0;
        msg_inpt_rdy_i = 1'b1;
        #3;
        chk("rst_byte_rdy", 64'(byte_rdy_o), 64'd1);
        chk("rst_vld", 64'(msg_inpt_vld_o), 64'd0);
        chk("rst_d", 64'(msg_inpt_d_o), 64'd0);
        chk("rst_mask", 64'(msg_inpt_vld_byte_o), 64'd0);
        chk("rst_lst", 64'(msg_inpt_lst_o), 64'd0);
        chk("rst_len", msg_len_bits_o, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // 1: "abc"
        expect_word(32'h61626300, 4'b1110, 1'b1);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
        chk("t1_latency_vld", 64'(msg_inpt_vld_o), 64'd1);
        chk("t1_len", msg_len_bits_o, 64'd24);
        @(posedge clk_i);
        #1;
        chk("t1_busy_after_pop", 64'(busy_o), 64'd0);
        chk("t1_len_hold", msg_len_bits_o, 64'd24);
        drain("t1_drain");

        // 2: eight bytes, two full words
        expect_word(32'h00010203, 4'b1111, 1'b0);
        expect_word(32'h04050607, 4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) send(8'(k), (k == 7));
        chk("t2_len", msg_len_bits_o, 64'd64);
        drain("t2_drain");

        // 3: backpressure with 12 bytes
        msg_inpt_rdy_i = 1'b0;
        expect_word(32'h20212223, 4'b1111, 1'b0);
        expect_word(32'h24252627, 4'b1111, 1'b0);
        expect_word(32'h28292a2b, 4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) send(8'(8'h20 + k), 1'b0);
        chk("t3_byte_rdy_low", 64'(byte_rdy_o), 64'd0);
        chk("t3_head_d", 64'(msg_inpt_d_o), 64'h20212223);
        repeat (3) @(posedge clk_i);
        #1;
        chk("t3_head_stable", 64'(msg_inpt_d_o), 64'h20212223);
        chk("t3_head_vld", 64'(msg_inpt_vld_o), 64'd1);
        byte_i         = 8'h28;
        byte_vld_i     = 1'b1;
        msg_inpt_rdy_i = 1'b1;
        chk("t3_rdy_before_pop", 64'(byte_rdy_o), 64'd0);
        @(posedge clk_i);
        #1;
        chk("t3_rdy_after_pop", 64'(byte_rdy_o), 64'd1);
        send(8'h28, 1'b0);
        send(8'h29, 1'b0);
        send(8'h2a, 1'b0);
        send(8'h2b, 1'b1);
        chk("t3_len", msg_len_bits_o, 64'd96);
        drain("t3_drain");

        // 4: back-to-back messages
        expect_word(32'h31323334, 4'b1111, 1'b0);
        expect_word(32'h35000000, 4'b1000, 1'b1);
        expect_word(32'haa000000, 4'b1000, 1'b1);
        for (int k = 0; k < 5; k++) send(8'(8'h31 + k), (k == 4));
        chk("t4_len_a", msg_len_bits_o, 64'd40);
        send(8'haa, 1'b1);
        chk("t4_len_b", msg_len_bits_o, 64'd8);
        drain("t4_drain");

        // 5: abort with a pending word and a partial word
        msg_inpt_rdy_i = 1'b0;
        for (int k = 0; k < 6; k++) send(8'(k + 1), 1'b0);
        chk("t5_busy_pre", 64'(busy_o), 64'd1);
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        chk("t5_vld", 64'(msg_inpt_vld_o), 64'd0);
        chk("t5_busy", 64'(busy_o), 64'd0);
        chk("t5_len", msg_len_bits_o, 64'd0);
        sb_q.delete();
        msg_inpt_rdy_i = 1'b1;
        expect_word(32'h11000000, 4'b1000, 1'b1);
        send(8'h11, 1'b1);
        drain("t5_drain");

        // 6: asynchronous reset mid-word
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        send(8'h73, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_vld", 64'(msg_inpt_vld_o), 64'd0);
        chk("t6_len", msg_len_bits_o, 64'd0);
        chk("t6_busy", 64'(busy_o), 64'd0);
        chk("t6_byte_rdy", 64'(byte_rdy_o), 64'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        expect_word(32'h81000000, 4'b1000, 1'b1);
        send(8'h81, 1'b1);
        chk("t6_len_after", msg_len_bits_o, 64'd8);
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
